// File: rtl/cam_pkg.sv
// Shared CAM definitions: default geometry, clog2 helper, and sequencer state encodings.
// No logic and no latency.
// No handshakes of its own.
package cam_pkg;

    localparam int CAM_DEPTH_DFLT  = 8;
    localparam int ADDR_WIDTH_DFLT = 3;

    // Constant-foldable ceiling log2, used to size the row address from the depth.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    typedef enum logic [0:0] {
        SEQ_IDLE = 1'b0,
        SEQ_EMIT = 1'b1
    } seq_state_t;

endpackage

// File: rtl/cam_priority_encoder.sv
// Finds the lowest set bit of a vector and reports whether any bit is set.
// Purely combinational, zero latency.
// No handshake; the caller qualifies the result.
module cam_priority_encoder #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic [DEPTH-1:0] vec,
    output logic [AW-1:0]    idx,
    output logic             any
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = AW'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_match_sequencer.sv
// Serialises a multi-hot CAM match vector into row addresses, lowest first; empty vector gives one miss.
// One cycle from accept to first out_valid; one result per cycle while out_ready stays high.
// Holds the result while out_ready is low; takes a new vector only when idle or on the last transfer.
// Optional feature macro: CAM_MATCH_COUNT_EN adds out_count (popcount of the accepted vector).
module cam_match_sequencer
    import cam_pkg::*;
#(
    parameter int CAM_DEPTH  = CAM_DEPTH_DFLT,
    parameter int ADDR_WIDTH = clog2(CAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CAM_DEPTH-1:0]  match_vec,
    input  logic                  match_valid,
    output logic                  match_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_hit,
    output logic                  out_last
`ifdef CAM_MATCH_COUNT_EN
    ,
    output logic [ADDR_WIDTH:0]   out_count
`endif
);

    localparam logic [CAM_DEPTH-1:0] ONE_HOT0 = CAM_DEPTH'(1);

    seq_state_t            state_q, state_d;
    logic [CAM_DEPTH-1:0]  pending_q, pending_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  hit_q, hit_d;
    logic                  last_q, last_d;

    logic                  take;
    logic                  accept;
    logic [CAM_DEPTH-1:0]  enc_vec;
    logic [CAM_DEPTH-1:0]  enc_rest;
    logic [ADDR_WIDTH-1:0] enc_idx;
    logic                  enc_any;

    assign out_valid   = (state_q == SEQ_EMIT);
    assign take        = out_valid & out_ready;
    assign match_ready = (state_q == SEQ_IDLE) | (take & last_q);
    assign accept      = match_valid & match_ready;

    // A single encoder serves both a fresh search and the remaining pending bits;
    // only one of the two can be consumed in any cycle.
    assign enc_vec  = accept ? match_vec : pending_q;
    assign enc_rest = enc_vec & ~(ONE_HOT0 << enc_idx);

    cam_priority_encoder #(
        .DEPTH (CAM_DEPTH),
        .AW    (ADDR_WIDTH)
    ) u_penc (
        .vec (enc_vec),
        .idx (enc_idx),
        .any (enc_any)
    );

    // Next-state and next-result selection: load, advance, retire, or hold.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        addr_d    = addr_q;
        hit_d     = hit_q;
        last_d    = last_q;
        if (accept) begin
            state_d   = SEQ_EMIT;
            addr_d    = enc_idx;
            hit_d     = enc_any;
            pending_d = enc_rest;
            last_d    = (enc_rest == '0);
        end else if (take && !last_q) begin
            addr_d    = enc_idx;
            hit_d     = 1'b1;
            pending_d = enc_rest;
            last_d    = (enc_rest == '0);
        end else if (take) begin
            state_d   = SEQ_IDLE;
            addr_d    = '0;
            hit_d     = 1'b0;
            last_d    = 1'b0;
            pending_d = '0;
        end
    end

    // State and result registers; reset drops any search in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEQ_IDLE;
            pending_q <= '0;
            addr_q    <= '0;
            hit_q     <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            addr_q    <= addr_d;
            hit_q     <= hit_d;
            last_q    <= last_d;
        end
    end

    assign out_addr = addr_q;
    assign out_hit  = hit_q;
    assign out_last = last_q;

`ifdef CAM_MATCH_COUNT_EN
    logic [ADDR_WIDTH:0] pop;
    logic [ADDR_WIDTH:0] count_q;

    // Number of set bits in the incoming vector, latched only on accept.
    always_comb begin
        pop = '0;
        for (int i = 0; i < CAM_DEPTH; i++) begin
            pop = pop + (ADDR_WIDTH + 1)'(match_vec[i]);
        end
    end

    // Count is frozen for every result belonging to the same search.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= pop;
        end
    end

    assign out_count = count_q;
`endif

endmodule

// File: tb/tb_cam_match_sequencer.sv
module tb_cam_match_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] match_vec;
    logic       match_valid;
    logic       match_ready;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_addr;
    logic       out_hit;
    logic       out_last;
`ifdef CAM_MATCH_COUNT_EN
    logic [3:0] out_count;
`endif

    int checks   = 0;
    int failures = 0;

    cam_match_sequencer #(.CAM_DEPTH(8), .ADDR_WIDTH(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .match_vec   (match_vec),
        .match_valid (match_valid),
        .match_ready (match_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_hit     (out_hit),
        .out_last    (out_last)
`ifdef CAM_MATCH_COUNT_EN
        ,
        .out_count   (out_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mv;
        logic [7:0] vec;
        logic       ordy;
        logic       exp_ov;
        logic       exp_mr;
        logic [2:0] exp_addr;
        logic       exp_hit;
        logic       exp_last;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic mv, logic [7:0] vec, logic ordy, logic ov,
                                logic mr, logic [2:0] addr, logic hit, logic last);
        vec_t v;
        v.mv = mv; v.vec = vec; v.ordy = ordy; v.exp_ov = ov;
        v.exp_mr = mr; v.exp_addr = addr; v.exp_hit = hit; v.exp_last = last;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs after the falling edge and sample outputs 1ns later, well clear of posedge.
    task automatic drive(input logic mv, input logic [7:0] vec, input logic ordy);
        @(negedge clk);
        match_valid = mv;
        match_vec   = vec;
        out_ready   = ordy;
        #1;
    endtask

    initial begin
        rst = 1'b1; match_valid = 1'b0; match_vec = 8'h00; out_ready = 1'b0;

        //              mv  vec           ordy ov  mr  addr hit last
        // 1: empty vector gives a single miss, then idle
        tbl.push_back(mk(1, 8'h00,        1,   0,  1,  0,   0,  0));
        tbl.push_back(mk(0, 8'h00,        1,   1,  1,  0,   0,  1));
        tbl.push_back(mk(0, 8'h00,        1,   0,  1,  0,   0,  0));
        // 2: two hits back to back
        tbl.push_back(mk(1, 8'b0010_0100, 1,   0,  1,  0,   0,  0));
        tbl.push_back(mk(0, 8'h00,        1,   1,  0,  2,   1,  0));
        tbl.push_back(mk(0, 8'h00,        1,   1,  1,  5,   1,  1));
        tbl.push_back(mk(0, 8'h00,        1,   0,  1,  0,   0,  0));
        // 3: back-pressure holds addr 0, then top row 7; offer while busy is ignored
        tbl.push_back(mk(1, 8'h81,        0,   0,  1,  0,   0,  0));
        tbl.push_back(mk(0, 8'h00,        0,   1,  0,  0,   1,  0));
        tbl.push_back(mk(0, 8'h00,        0,   1,  0,  0,   1,  0));
        tbl.push_back(mk(0, 8'h00,        0,   1,  0,  0,   1,  0));
        tbl.push_back(mk(0, 8'h00,        1,   1,  0,  0,   1,  0));
        tbl.push_back(mk(1, 8'h55,        0,   1,  0,  7,   1,  1));
        tbl.push_back(mk(0, 8'h00,        1,   1,  1,  7,   1,  1));
        tbl.push_back(mk(0, 8'h00,        1,   0,  1,  0,   0,  0));
        // 4: new search accepted on the last transfer, no bubble
        tbl.push_back(mk(1, 8'h02,        1,   0,  1,  0,   0,  0));
        tbl.push_back(mk(1, 8'h10,        1,   1,  1,  1,   1,  1));
        tbl.push_back(mk(0, 8'h00,        1,   1,  1,  4,   1,  1));
        tbl.push_back(mk(0, 8'h00,        1,   0,  1,  0,   0,  0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_match_ready", 32'(match_ready), 1);
        chk("reset_out_addr", 32'(out_addr), 0);
        chk("reset_out_hit", 32'(out_hit), 0);
        chk("reset_out_last", 32'(out_last), 0);
`ifdef CAM_MATCH_COUNT_EN
        chk("reset_out_count", 32'(out_count), 0);
`endif

        foreach (tbl[i]) begin
            drive(tbl[i].mv, tbl[i].vec, tbl[i].ordy);
            chk($sformatf("row%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
            chk($sformatf("row%0d_match_ready", i), 32'(match_ready), 32'(tbl[i].exp_mr));
            chk($sformatf("row%0d_out_hit", i), 32'(out_hit), 32'(tbl[i].exp_hit));
            chk($sformatf("row%0d_out_last", i), 32'(out_last), 32'(tbl[i].exp_last));
            if (tbl[i].exp_ov) begin
                chk($sformatf("row%0d_out_addr", i), 32'(out_addr), 32'(tbl[i].exp_addr));
            end
        end

        // 5: reset after two transfers of 8'hFF discards the rest
        drive(1, 8'hFF, 1);
        chk("rst_seq_accept_ready", 32'(match_ready), 1);
        drive(0, 8'h00, 1);
        chk("rst_seq_addr0", 32'(out_addr), 0);
        drive(0, 8'h00, 1);
        chk("rst_seq_addr1", 32'(out_addr), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_seq_addr2_before_rst", 32'(out_addr), 2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_seq_out_valid", 32'(out_valid), 0);
        chk("rst_seq_match_ready", 32'(match_ready), 1);
        for (int k = 0; k < 3; k++) begin
            drive(0, 8'h00, 1);
            chk($sformatf("rst_seq_no_stale%0d", k), 32'(out_valid), 0);
        end
        drive(1, 8'h00, 1);
        drive(0, 8'h00, 1);
        chk("rst_seq_post_miss_valid", 32'(out_valid), 1);
        chk("rst_seq_post_miss_hit", 32'(out_hit), 0);
        chk("rst_seq_post_miss_last", 32'(out_last), 1);

        // 6: full vector walks 0..7, then a miss; count checked when the feature is built in
        drive(1, 8'hFF, 1);
        for (int k = 0; k < 8; k++) begin
            drive(0, 8'h00, 1);
            chk($sformatf("ff_addr%0d", k), 32'(out_addr), 32'(k));
            chk($sformatf("ff_last%0d", k), 32'(out_last), 32'(k == 7));
            chk($sformatf("ff_valid%0d", k), 32'(out_valid), 1);
`ifdef CAM_MATCH_COUNT_EN
            chk($sformatf("ff_count%0d", k), 32'(out_count), 8);
`endif
        end
        drive(1, 8'h00, 1);
        chk("ff_done_idle", 32'(out_valid), 0);
        drive(0, 8'h00, 1);
        chk("zero_hit", 32'(out_hit), 0);
        chk("zero_last", 32'(out_last), 1);
`ifdef CAM_MATCH_COUNT_EN
        chk("zero_count", 32'(out_count), 0);
`endif
        drive(0, 8'h00, 1);
        chk("zero_done_idle", 32'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
